// File: rtl/fht_result_reader.sv
// Streams the FHT spectrum out of the four RAM banks as one valid/ready sample stream,
// optionally undoing the bank bit-reverse ordering so the host sees natural order.
module fht_result_reader #(
    parameter int D_BIT  = 17,
    parameter int A_BIT  = 8,
    parameter int RD_LAT = 2
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iFHT_RDY,
    input  logic             iSTART,
    input  logic             iBIT_REV,
    output logic [A_BIT-1:0] oADDR_RD,
    input  logic [D_BIT-1:0] iDATA_0,
    input  logic [D_BIT-1:0] iDATA_1,
    input  logic [D_BIT-1:0] iDATA_2,
    input  logic [D_BIT-1:0] iDATA_3,
    output logic [D_BIT-1:0] oDATA,
    output logic             oVALID,
    input  logic             iREADY,
    output logic [A_BIT+1:0] oINDEX,
    output logic             oLAST,
    output logic             oBUSY,
    output logic             oDONE,
    output logic             oERR
);
    // Stream handshake: a sample transfers on a rising edge where oVALID & iREADY;
    // once raised, oVALID and the sample fields hold until that transfer happens.

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state;
    logic             bit_rev;
    logic [A_BIT:0]   fr;
    logic [RD_LAT:0]  pipe;
    logic [D_BIT-1:0] slot [2][4];
    logic [1:0]       full;
    logic             head;
    logic             tail;
    logic [1:0]       ob;
    logic [A_BIT-1:0] orow;

    logic [D_BIT-1:0] in_row [4];
    logic [D_BIT-1:0] row_n  [4];
    logic [D_BIT-1:0] sample_n;
    logic             hs, free, cap, issue, last_hs, head_n;
    logic [2:0]       inflight, occ;
    logic [1:0]       full_n, ob_n;
    logic [A_BIT-1:0] orow_n;

    assign in_row[0] = iDATA_0;
    assign in_row[1] = iDATA_1;
    assign in_row[2] = iDATA_2;
    assign in_row[3] = iDATA_3;

    function automatic logic [A_BIT-1:0] bitrev(input logic [A_BIT-1:0] x);
        logic [A_BIT-1:0] r;
        r = '0;
        for (int i = 0; i < A_BIT; i++) r[i] = x[A_BIT-1-i];
        return r;
    endfunction

    always_comb begin
        hs       = oVALID & iREADY;
        free     = hs & (ob == 2'd3);
        cap      = pipe[RD_LAT] & (state == S_RUN);
        last_hs  = hs & oLAST;
        inflight = '0;
        for (int i = 0; i <= RD_LAT; i++) inflight = inflight + {2'b00, pipe[i]};
        occ      = {2'b00, full[0]} + {2'b00, full[1]};
        // A slot freed on this edge can be refilled by a fetch issued on the same edge.
        issue    = (state == S_RUN) && !fr[A_BIT] &&
                   ((occ + inflight) < (3'd2 + {2'b00, free}));
        full_n   = full;
        if (free) full_n[head] = 1'b0;
        if (cap)  full_n[tail] = 1'b1;
        head_n   = head ^ free;
        ob_n     = hs ? ob + 2'd1 : ob;
        orow_n   = orow + {{(A_BIT-1){1'b0}}, free};
        for (int b = 0; b < 4; b++)
            row_n[b] = (cap && (tail == head_n)) ? in_row[b] : slot[head_n][b];
        sample_n = row_n[ob_n];
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state    <= S_IDLE;
            bit_rev  <= 1'b0;
            fr       <= '0;
            pipe     <= '0;
            full     <= '0;
            head     <= 1'b0;
            tail     <= 1'b0;
            ob       <= '0;
            orow     <= '0;
            for (int s = 0; s < 2; s++)
                for (int b = 0; b < 4; b++) slot[s][b] <= '0;
            oADDR_RD <= '0;
            oDATA    <= '0;
            oVALID   <= 1'b0;
            oINDEX   <= '0;
            oLAST    <= 1'b0;
            oBUSY    <= 1'b0;
            oDONE    <= 1'b0;
            oERR     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    oDONE <= 1'b0;
                    pipe  <= {pipe[RD_LAT-1:0], 1'b0};
                    if (iSTART && iFHT_RDY) begin
                        state    <= S_RUN;
                        bit_rev  <= iBIT_REV;
                        oERR     <= 1'b0;
                        oBUSY    <= 1'b1;
                        oADDR_RD <= '0;
                        fr       <= (A_BIT+1)'(1);
                        pipe     <= (RD_LAT+1)'(1);
                        full     <= '0;
                        head     <= 1'b0;
                        tail     <= 1'b0;
                        ob       <= '0;
                        orow     <= '0;
                        oVALID   <= 1'b0;
                        oINDEX   <= '0;
                        oLAST    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!iFHT_RDY) oERR <= 1'b1;
                    pipe <= {pipe[RD_LAT-1:0], issue};
                    if (issue) begin
                        oADDR_RD <= bit_rev ? bitrev(fr[A_BIT-1:0]) : fr[A_BIT-1:0];
                        fr       <= fr + 1'b1;
                    end
                    if (cap) begin
                        for (int b = 0; b < 4; b++) slot[tail][b] <= in_row[b];
                        tail <= ~tail;
                    end
                    full <= full_n;
                    head <= head_n;
                    ob   <= ob_n;
                    orow <= orow_n;
                    if (last_hs) begin
                        state  <= S_DONE;
                        oBUSY  <= 1'b0;
                        oVALID <= 1'b0;
                        oLAST  <= 1'b0;
                        oDONE  <= 1'b1;
                    end else begin
                        oVALID <= full_n[head_n];
                        if (full_n[head_n]) begin
                            oDATA  <= sample_n;
                            oINDEX <= {orow_n, ob_n};
                            oLAST  <= &{orow_n, ob_n};
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    oDONE <= 1'b0;
                    pipe  <= {pipe[RD_LAT-1:0], 1'b0};
                end
            endcase
        end
    end

endmodule

// File: doc/fht_result_reader.md
# fht_result_reader

Read-out engine on the output side of `fht_top`. Once the transform reports ready, it walks the four RAM banks through the shared read-address port and returns the spectrum as one serial sample stream with valid/ready back-pressure. It can undo the bank bit-reverse ordering on the fly, so the host sees natural order. It replaces direct bench access to bank memory with a synthesizable path from the FHT RAM to the downstream host/DMA.

## Interface

Parameters:
- `D_BIT`, 17: sample width (signed, already bit-expanded by the FHT).
- `A_BIT`, 8: bank address width; `BANK_SIZE = 2**A_BIT` rows; total samples `N = 4*BANK_SIZE`.
- `RD_LAT`, 2: RAM read latency in cycles, from address presented to data valid on `iDATA_x`. Legal range 1..3.

Ports:
- `iCLK` in 1: single clock, rising edge.
- `iRESET` in 1: asynchronous, active-high reset.
- `iFHT_RDY` in 1: `fht_top` `oRDY` (level).
- `iSTART` in 1: one-cycle request to start a read-out.
- `iBIT_REV` in 1: sampled at accepted start. 1 = bit-reverse the row address (natural order); 0 = stored order.
- `oADDR_RD` out A_BIT: drives `iADDR_RD_0..3` of `fht_top` together.
- `iDATA_0`..`iDATA_3` in D_BIT each: `fht_top` `oDATA_0..3`.
- `oDATA` out D_BIT: stream sample.
- `oVALID` out 1: `oDATA` is valid.
- `iREADY` in 1: downstream accepts a sample.
- `oINDEX` out A_BIT+2: sample index `4*row + bank`.
- `oLAST` out 1: high with the sample at index N-1.
- `oBUSY` out 1: read-out in progress.
- `oDONE` out 1: one-cycle pulse at completion.
- `oERR` out 1: sticky; `iFHT_RDY` dropped during a read-out.

## Operation

- **Start acceptance:** `iSTART` is accepted only when `oBUSY=0` and `iFHT_RDY=1`. Otherwise it is ignored and has no side effects. Acceptance latches `iBIT_REV`, clears `oERR` and zeroes all counters.
- **Fetch engine:** row counter `fr` runs 0..BANK_SIZE-1.
  - Issues `oADDR_RD = iBIT_REV ? bitrev(fr) : fr`, at most one row per cycle.
  - Captures `{iDATA_3..iDATA_0}` exactly RD_LAT cycles after issue into a two-slot row buffer (ping-pong).
  - Issues only while slots occupied + rows in flight < 2. Otherwise `oADDR_RD` holds its last value.
- **Output engine:** bank counter `ob` (0..3) and row counter `orow`.
  - `oDATA = slot[head][ob]`; `oVALID=1` while the head slot is full.
  - A handshake (`oVALID & iREADY`) advances `ob`. Wrap 3→0 frees the slot, toggles `head` and increments `orow`.
- **Data path:** values pass unmodified. No rounding, saturation or sign change; D_BIT in equals D_BIT out.
- **Completion:** the handshake on index N-1 has `oLAST=1`.
  - Next cycle: `oDONE=1`, `oBUSY=0`, `oVALID=0`.
  - `oDATA` and `oINDEX` hold the last values.
- **FSM states:**
  - IDLE →(accepted start)→ RUN.
  - RUN →(last handshake)→ DONE.
  - DONE →(next cycle)→ IDLE.
  - `oBUSY=1` in RUN only.
- **`iFHT_RDY` drop in RUN:** sets `oERR`. The read-out still completes normally. `oERR` stays high until the next accepted start.
- **Reset:** `iRESET` asserted at any time, including mid-stream, immediately forces all outputs to 0, discards buffered rows and returns the FSM to IDLE. In-flight RAM data returning after reset is ignored.

## Timing

- **Reset values:** every output is 0: `oADDR_RD`, `oDATA`, `oVALID`, `oINDEX`, `oLAST`, `oBUSY`, `oDONE`, `oERR`.
- **Start-up latency:** `iSTART` sampled at edge 0.
  - Cycle 1: `oBUSY=1`, `oADDR_RD` = row 0 address.
  - Cycle 1+RD_LAT: data arrives on `iDATA_x`; captured at the end of that cycle.
  - Cycle 2+RD_LAT: first `oVALID` (cycle 4 at RD_LAT=2).
- **Throughput:** with `iREADY` held high, one sample per cycle with no bubbles, because row fetch (RD_LAT+1 ≤ 4 cycles) hides behind a 4-sample row. The last sample is at cycle 2+RD_LAT+N-1; `oDONE` is one cycle later.
- **Back-pressure:** while `oVALID=1` and `iREADY=0`, `oDATA`, `oINDEX` and `oLAST` hold stable. `oVALID` never drops before the handshake.
- **Simultaneous events:**
  - `iSTART` in the DONE cycle is ignored (`oBUSY` falls there, but acceptance requires IDLE).
  - `iSTART` and `iRESET` together: reset wins.

## Test plan

1. **Stored order.** A_BIT=3, RD_LAT=2, RAM model word(row r, bank b) = 4r+b, `iBIT_REV=0`, `iREADY=1`. Expect `oDATA` = 0..31 at cycles 4..35, `oINDEX` = `oDATA`, `oLAST` at cycle 35, `oDONE` at cycle 36.
2. **Natural order.** Same model with `iBIT_REV=1`. Expect row j read at address bitrev3(j): indices 4..7 → 16,17,18,19; indices 12..15 → 24..27. `oADDR_RD` sequence is 0,4,2,6,1,5,3,7.
3. **Back-pressure.** Random `iREADY` at 50%, plus `iREADY=0` for 20 cycles at index 6. Expect exactly 32 samples in order with no loss or duplication, outputs stable while stalled, and `oADDR_RD` never more than 2 rows ahead of `orow`.
4. **Ignored starts.** `iSTART` with `iFHT_RDY=0`: `oBUSY` stays 0 and the stream is empty. `iSTART` pulsed at index 10 mid-run: the sequence is unchanged and there is exactly one `oDONE`.
5. **Signed data and error flag.** Bank data -1 (all ones) and −2^(D_BIT-1): expect bit-exact output. Drop `iFHT_RDY` at index 9: `oERR=1` from the next cycle through `oDONE`, cleared at the next accepted start.
6. **Reset mid-stream.** Assert `iRESET` at index 13: all outputs are 0 asynchronously. After release, a new `iSTART` restarts from index 0 with the correct data and no stale rows.
